logic_gate_unit: RTL

LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

---
 rtl/logic_gate_unit_pkg.sv | 47 ++++
 rtl/logic_gate_unit_core.sv | 34 +++
 rtl/logic_gate_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/logic_gate_unit_pkg.sv
`default_nettype none
// =============================================================================
// Module      : logic_gate_unit_pkg
// Description : Gate-select encodings, gate truth table and BIST FSM states.
// Revision    : 1.0 - initial release
// =============================================================================
package logic_gate_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NAND  = 3'd3,
        OP_NOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOT_A = 3'd6,
        OP_PASS_A= 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    // Row per op; bit {a,b} of a row is the gate output for that input pair.
    localparam logic [7:0][3:0] TT = {
        4'b1100,  // PASS_A
        4'b0011,  // NOT_A
        4'b1001,  // XNOR
        4'b0001,  // NOR
        4'b0111,  // NAND
        4'b0110,  // XOR
        4'b1110,  // OR
        4'b1000   // AND
    };

    localparam logic [4:0] BIST_LAST_IDX = 5'd31;

    function automatic logic tt_bit(input logic [2:0] op, input logic a, input logic b);
        return TT[op][{a, b}];
    endfunction

endpackage : logic_gate_unit_pkg
`default_nettype wire

// File: rtl/logic_gate_unit_core.sv
`default_nettype none
// =============================================================================
// Module      : logic_gate_core
// Description : Bitwise gate datapath selected by op (purely combinational).
// Revision    : 1.0 - initial release
// =============================================================================
module logic_gate_core
    import logic_gate_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_NAND:   y = ~(a & b);
            OP_NOR:    y = ~(a | b);
            OP_XNOR:   y = ~(a ^ b);
            OP_NOT_A:  y = ~a;
            OP_PASS_A: y = a;
            default:   y = '0;
        endcase
    end

endmodule : logic_gate_core
`default_nettype wire

// File: rtl/logic_gate_unit.sv
`default_nettype none
// =============================================================================
// Module      : logic_gate_unit
// Description : Registered bitwise gate unit with valid/ready handshake and BIST.
// Revision    : 1.0 - initial release
// =============================================================================
module logic_gate_unit
    import logic_gate_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ERRW  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             bist_start,
    input  logic             bist_fault_inj,
    output logic             bist_busy,
    output logic             bist_done,
    output logic             bist_pass,
    output logic [ERRW-1:0]  bist_err
);

    localparam logic [ERRW-1:0] c_err_max = {ERRW{1'b1}};

    bist_state_e      r_state;
    bist_state_e      w_state_nxt;
    logic [4:0]       r_idx;
    logic [WIDTH-1:0] r_y;
    logic             r_out_valid;
    logic             r_rdy_en;
    logic             r_chk_valid;
    logic [WIDTH-1:0] r_chk_y;
    logic [4:0]       r_chk_idx;
    logic [ERRW-1:0]  r_err;
    logic             r_pass;

    logic             w_run;
    logic             w_accept;
    logic             w_start_ok;
    logic [WIDTH-1:0] w_core_a;
    logic [WIDTH-1:0] w_core_b;
    logic [2:0]       w_core_op;
    logic [WIDTH-1:0] w_core_y;
    logic [WIDTH-1:0] w_bist_y;
    logic             w_exp_bit;
    logic             w_mismatch;

    assign w_run      = (r_state == ST_RUN);
    assign w_start_ok = (r_state == ST_IDLE) && bist_start;
    assign in_ready   = r_rdy_en && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;

    // External beats never arrive during RUN, so the core can be time-shared.
    assign w_core_a  = w_run ? {WIDTH{r_idx[1]}} : a;
    assign w_core_b  = w_run ? {WIDTH{r_idx[0]}} : b;
    assign w_core_op = w_run ? r_idx[4:2] : op;

    logic_gate_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a  (w_core_a),
        .b  (w_core_b),
        .op (w_core_op),
        .y  (w_core_y)
    );

    assign w_bist_y   = {w_core_y[WIDTH-1:0]} ^ {{(WIDTH-1){1'b0}}, bist_fault_inj};
    assign w_exp_bit  = tt_bit(r_chk_idx[4:2], r_chk_idx[1], r_chk_idx[0]);
    assign w_mismatch = r_chk_valid && (r_chk_y != {WIDTH{w_exp_bit}});

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bist_start) w_state_nxt = r_out_valid ? ST_DRAIN : ST_RUN;
            ST_DRAIN: if (!r_out_valid || out_ready) w_state_nxt = ST_RUN;
            ST_RUN:   if (r_idx == BIST_LAST_IDX) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_rdy_en    <= 1'b0;
            r_chk_valid <= 1'b0;
            r_chk_y     <= '0;
            r_chk_idx   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_run ? r_idx + 5'd1 : 5'd0;
            r_rdy_en    <= 1'b1;
            r_chk_valid <= w_run;
            r_chk_y     <= w_bist_y;
            r_chk_idx   <= r_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_y         <= w_core_y;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err  <= '0;
            r_pass <= 1'b0;
        end else if (w_start_ok) begin
            r_err  <= '0;
            r_pass <= 1'b0;
        end else begin
            if (w_mismatch && (r_err != c_err_max)) begin
                r_err <= r_err + 1'b1;
            end
            if (r_state == ST_DONE) begin
                r_pass <= (r_err == '0);
            end
        end
    end

    assign y         = r_y;
    assign out_valid = r_out_valid;
    assign bist_busy = (r_state == ST_DRAIN) || (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign bist_done = (r_state == ST_DONE);
    assign bist_pass = r_pass;
    assign bist_err  = r_err;

endmodule : logic_gate_unit
`default_nettype wire
